syn_tle_gemm: RTL and testbench
===============================

Name: syn_tle_gemm

Overview:
Pipelined signed matrix multiply-accumulate tile: D = A×B + C, where A is M×K, B is K×N and C/D are M×N.
- All M·N dot products of length K are computed in parallel and registered through PIPESTAGES stages.
- Valid/ready handshake on both sides.
- Used as the compute tile inside the systolic/GEMM datapath.

Parameters:
- M, 2: rows of A and D.
- N, 2: columns of B and D.
- K, 2: reduction length (columns of A, rows of B); ≥1.
- P, 8: element width of A and B, signed two's complement.
- PIPESTAGES, 2: number of register stages from input to D_o; ≥1.
- TREE, 0: 1 = balanced binary adder tree for the K-term reduction; 0 = linear adder chain. The choice is functionally identical and affects timing/area only.

Ports:
- clk_i, in, 1: clock; all logic is rising-edge.
- rst_ni, in, 1: asynchronous, active-high reset (port keeps the codebase name).
- A_i, in, signed P × [M][K]: A matrix.
- B_i, in, signed P × [K][N]: B matrix.
- C_i, in, signed 4P × [M][N]: accumulator input.
- valid_i, in, 1: input beat valid.
- ready_o, out, 1: tile accepts input this cycle.
- D_o, out, signed 4P × [M][N]: result.
- valid_o, out, 1: D_o valid.
- ready_i, in, 1: downstream accepts D_o.

Behaviour:
- Arithmetic:
  - Each product A[i][k]·B[k][j] is signed, 2P bits.
  - The K products are summed sign-extended to 4P bits.
  - C[i][j] is added; the result wraps modulo 2^(4P).
- Pipeline: PIPESTAGES stages, each holding a valid bit plus data.
  - PIPESTAGES=1: a single output register.
  - PIPESTAGES≥2: stage 1 registers the M·N reduced sums together with C; the final stage registers D. Stages 2..PIPESTAGES-1 are plain delay registers before the final add.
- Global stall: en = !valid_o || ready_i.
  - When en=1, every stage shifts by one; stage 1 loads valid_i and the data.
  - When en=0, all stages hold.
- ready_o = en, and is held 0 while reset is asserted.
- Input handshake: a beat is accepted when valid_i && ready_o. Bubbles are not collapsed.
- Latency: PIPESTAGES cycles from acceptance to valid_o with ready_i continuously high. Throughput is 1 beat/cycle.
- Output handshake: D_o/valid_o stay stable while valid_o && !ready_i. A transfer occurs on valid_o && ready_i.
- Reset (asynchronous, any time, including mid-operation):
  - All valid bits → 0, all data registers → 0, so D_o = 0 and valid_o = 0.
  - In-flight beats are discarded.
  - ready_o = 1 on the first cycle after release.
- Data-register enables: data registers load only when en=1. Payload of invalid stages is don't-care, but must not become X after reset.
- Simultaneous events: an output transfer and an input acceptance in the same cycle are both performed (en=1).
- Full pipeline with ready_i=0: ready_o=0 and valid_i is ignored.

Optional Feature:
- Macro: SYN_TLE_SAT_EN.
- When defined: the final add uses 4P+1 bits and the result saturates to [−2^(4P−1), 2^(4P−1)−1].
- When undefined: wrap-around modulo 2^(4P).
- Applies to both TREE settings.

Test Plan:
- Reset then idle: hold rst_ni=1 for 2 cycles, then release → D_o all 0, valid_o=0, ready_o=1.
- Basic MAC with M=N=K=2, P=8: A all 1, B all 2, C all 3, one valid beat, ready_i=1 → after 2 cycles valid_o=1 for one cycle, every D=7.
- Backpressure: same beat with ready_i=0 for 5 cycles → valid_o stays 1, D=7 held, ready_o=0; raise ready_i → one transfer, then valid_o=0.
- Signed extremes, P=8: A=−128, B=−128, K=2, C=−1 → D=32767; A=127, B=−128, C=0 → D=−32512.
- Streaming: back-to-back beats with C=0,1,2,3 (A=B=1) and ready_i=1 → outputs 2,3,4,5 on consecutive cycles. Repeat with TREE=1 → identical results.
- Reset mid-flight / saturation:
  - Assert rst_ni while 2 beats are in flight → valid_o=0, no output ever appears.
  - With SYN_TLE_SAT_EN, C=2^31−1, A=B=1 → D=2^31−1.
  - Without SYN_TLE_SAT_EN, same stimulus → D wraps to −2^31+1.

Source files
------------

// File: rtl/syn_tle_gemm.sv
// ----------------------------------------------------------------------------
// syn_tle_gemm -- pipelined signed matrix multiply-accumulate tile.
//
// Computes D = A x B + C, where A is MxK, B is KxN and C/D are MxN. All M*N
// dot products of length K are formed in parallel. The result leaves through
// PIPESTAGES register stages under a valid/ready handshake on both sides.
//
// Optional feature macro: SYN_TLE_SAT_EN
//   defined   : the final add uses 4P+1 bits and saturates to the signed 4P range
//   undefined : the final add wraps modulo 2^(4P)
//
// Parameters
//   M, N, K     matrix dimensions (K >= 1)
//   P           element width of A and B (signed)
//   PIPESTAGES  register stages from input to D_o (>= 1)
//   TREE        1 = balanced adder tree, 0 = linear chain for the K-term sum
//
// Ports (flattened, row-major, element 0 in the LSBs)
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous reset, ACTIVE HIGH despite the name
//   A_i      in   [M*K*P]   A[i][k]  at bits (i*K+k)*P   +: P
//   B_i      in   [K*N*P]   B[k][j]  at bits (k*N+j)*P   +: P
//   C_i      in   [M*N*4P]  C[i][j]  at bits (i*N+j)*4P  +: 4P
//   valid_i  in   input beat valid
//   ready_o  out  tile accepts a beat this cycle
//   D_o      out  [M*N*4P]  D[i][j], same layout as C_i
//   valid_o  out  D_o valid
//   ready_i  in   downstream accepts D_o
// ----------------------------------------------------------------------------
module syn_tle_gemm #(
  parameter int M          = 2,
  parameter int N          = 2,
  parameter int K          = 2,
  parameter int P          = 8,
  parameter int PIPESTAGES = 2,
  parameter int TREE       = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [M*K*P-1:0]     A_i,
  input  logic [K*N*P-1:0]     B_i,
  input  logic [M*N*4*P-1:0]   C_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [M*N*4*P-1:0]   D_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int W   = 4 * P;
  localparam int MN  = M * N;
  // Leaf count of the adder tree, rounded up to a power of two.
  localparam int KP2 = (K <= 1) ? 1 : (1 << $clog2(K));

  // Signed PxP product, sign-extended to the 4P accumulation width.
  function automatic logic signed [W-1:0] mul_ext(input logic [P-1:0] a,
                                                  input logic [P-1:0] b);
    logic signed [2*P-1:0] a_x;
    logic signed [2*P-1:0] b_x;
    logic signed [2*P-1:0] prod;
    a_x  = {{P{a[P-1]}}, a};
    b_x  = {{P{b[P-1]}}, b};
    prod = a_x * b_x;
    return {{(W-2*P){prod[2*P-1]}}, prod};
  endfunction

  // --------------------------------------------------------------------------
  // K-term reductions, one per output element
  // --------------------------------------------------------------------------
  logic [MN*W-1:0] sum_flat;

  genvar gi, gj, ge;
  for (gi = 0; gi < M; gi++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      if (TREE != 0) begin : g_tree
        // Heap-ordered tree: leaves at KP2..2*KP2-1, root at index 1.
        // Unused leaves are zero so they do not disturb the sum.
        logic signed [W-1:0] node [1:2*KP2-1];
        always_comb begin
          for (int n = 1; n < 2 * KP2; n++) begin
            node[n] = '0;
          end
          for (int k = 0; k < K; k++) begin
            node[KP2+k] = mul_ext(A_i[(gi*K+k)*P +: P], B_i[(k*N+gj)*P +: P]);
          end
          for (int n = KP2 - 1; n >= 1; n--) begin
            node[n] = node[2*n] + node[2*n+1];
          end
        end
        assign sum_flat[(gi*N+gj)*W +: W] = node[1];
      end else begin : g_chain
        logic signed [W-1:0] acc;
        always_comb begin
          acc = '0;
          for (int k = 0; k < K; k++) begin
            acc = acc + mul_ext(A_i[(gi*K+k)*P +: P], B_i[(k*N+gj)*P +: P]);
          end
        end
        assign sum_flat[(gi*N+gj)*W +: W] = acc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Global stall and handshake
  // --------------------------------------------------------------------------
  logic                  en;
  logic [PIPESTAGES-1:0] valid_q;
  logic [MN*W-1:0]       d_q;
  logic [MN*W-1:0]       fin_sum;
  logic [MN*W-1:0]       fin_c;
  logic [MN*W-1:0]       fin_d;

  // Every stage advances together whenever the output slot is free or drained.
  assign en      = !valid_q[PIPESTAGES-1] || ready_i;
  // Reset clears valid_o which would otherwise make en (and ready_o) high.
  assign ready_o = en && !rst_ni;
  assign valid_o = valid_q[PIPESTAGES-1];
  assign D_o     = d_q;

  // Bubbles travel with the data: stage 0 always samples valid_i when en.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q[0] <= valid_i;
      for (int s = 1; s < PIPESTAGES; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data pipeline ahead of the final add
  // --------------------------------------------------------------------------
  if (PIPESTAGES == 1) begin : g_direct
    // Single stage: the final add happens straight off the inputs.
    assign fin_sum = sum_flat;
    assign fin_c   = C_i;
  end else begin : g_staged
    localparam int S = PIPESTAGES - 1;
    logic [MN*W-1:0] sum_q [S];
    logic [MN*W-1:0] c_q   [S];

    always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) begin
        for (int s = 0; s < S; s++) begin
          sum_q[s] <= '0;
          c_q[s]   <= '0;
        end
      end else if (en) begin
        sum_q[0] <= sum_flat;
        c_q[0]   <= C_i;
        for (int s = 1; s < S; s++) begin
          sum_q[s] <= sum_q[s-1];
          c_q[s]   <= c_q[s-1];
        end
      end
    end

    assign fin_sum = sum_q[S-1];
    assign fin_c   = c_q[S-1];
  end

  // --------------------------------------------------------------------------
  // Final accumulate, one adder per output element
  // --------------------------------------------------------------------------
  for (ge = 0; ge < MN; ge++) begin : g_fin
    logic signed [W-1:0] s_e;
    logic signed [W-1:0] c_e;
    assign s_e = fin_sum[ge*W +: W];
    assign c_e = fin_c[ge*W +: W];
`ifdef SYN_TLE_SAT_EN
    logic signed [W:0] wide;
    assign wide = {s_e[W-1], s_e} + {c_e[W-1], c_e};
    // The top two bits disagree only on overflow; the sign of the wide sum
    // picks the clamp value (0111..1 for positive, 1000..0 for negative).
    assign fin_d[ge*W +: W] = (wide[W] != wide[W-1]) ?
                              {wide[W], {(W-1){~wide[W]}}} : wide[W-1:0];
`else
    assign fin_d[ge*W +: W] = s_e + c_e;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      d_q <= '0;
    end else if (en) begin
      d_q <= fin_d;
    end
  end

endmodule

// File: tb/tb_syn_tle_gemm.sv
// ----------------------------------------------------------------------------
// tb_syn_tle_gemm -- self-checking bench for syn_tle_gemm.
//
// Two tiles share one input stream: dut0 (linear chain, 2 stages) and dut1
// (adder tree, 3 stages). Each has its own reference pipeline: a row of
// PIPESTAGES slots that all move one place whenever the last slot is empty
// or being taken. Slot contents are the matrix product worked out with plain
// integer arithmetic. Directed scenarios add literal expected values.
// ----------------------------------------------------------------------------
module tb_syn_tle_gemm;

  localparam int M  = 2;
  localparam int N  = 2;
  localparam int K  = 2;
  localparam int P  = 8;
  localparam int W  = 4 * P;
  localparam int MN = M * N;
  localparam int DW = MN * W;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic               clk;
  logic               rst;
  logic [M*K*P-1:0]   a_flat;
  logic [K*N*P-1:0]   b_flat;
  logic [DW-1:0]      c_flat;
  logic               valid_in;
  logic               ready_in;
  logic               rdy_o [2];
  logic               vld_o [2];
  logic [DW-1:0]      d_o   [2];

  int a_m [M][K];
  int b_m [K][N];
  int c_m [M][N];

  // Reference pipelines, one row per DUT.
  bit            mv [2][4];
  logic [DW-1:0] md [2][4];
  int            ps_of [2];

  int n_checks;
  int n_fail;

  syn_tle_gemm #(.M(M), .N(N), .K(K), .P(P), .PIPESTAGES(2), .TREE(0)) u_dut0 (
    .clk_i   (clk),
    .rst_ni  (rst),
    .A_i     (a_flat),
    .B_i     (b_flat),
    .C_i     (c_flat),
    .valid_i (valid_in),
    .ready_o (rdy_o[0]),
    .D_o     (d_o[0]),
    .valid_o (vld_o[0]),
    .ready_i (ready_in)
  );

  syn_tle_gemm #(.M(M), .N(N), .K(K), .P(P), .PIPESTAGES(3), .TREE(1)) u_dut1 (
    .clk_i   (clk),
    .rst_ni  (rst),
    .A_i     (a_flat),
    .B_i     (b_flat),
    .C_i     (c_flat),
    .valid_i (valid_in),
    .ready_o (rdy_o[1]),
    .D_o     (d_o[1]),
    .valid_o (vld_o[1]),
    .ready_i (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs,
                          input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // D = A*B + C from the current matrices; K-term sum kept to 4P bits.
  function automatic logic [DW-1:0] ref_d();
    logic [DW-1:0] r;
    longint        s;
    longint        t;
    int            s32;
    r = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < K; k++) begin
          s += longint'(a_m[i][k]) * longint'(b_m[k][j]);
        end
        s32 = int'(s[W-1:0]);
        t   = longint'(s32) + longint'(c_m[i][j]);
`ifdef SYN_TLE_SAT_EN
        if (t > SMAX) t = SMAX;
        else if (t < SMIN) t = SMIN;
`endif
        r[(i*N+j)*W +: W] = t[W-1:0];
      end
    end
    return r;
  endfunction

  task automatic pack();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++)
        a_flat[(i*K+k)*P +: P] = a_m[i][k][P-1:0];
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++)
        b_flat[(k*N+j)*P +: P] = b_m[k][j][P-1:0];
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        c_flat[(i*N+j)*W +: W] = c_m[i][j];
  endtask

  task automatic set_uniform(input int a, input int b, input int c);
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a_m[i][k] = a;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b_m[k][j] = b;
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) c_m[i][j] = c;
  endtask

  task automatic set_random();
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++)
      a_m[i][k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++)
      b_m[k][j] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++)
      c_m[i][j] = int'($urandom);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 4; s++) begin
        mv[d][s] = 1'b0;
        md[d][s] = '0;
      end
  endtask

  // One clock: drive inputs on the falling edge, compare outputs 1 ns later
  // against the reference, then advance the reference for the coming edge.
  task automatic step(input bit v, input bit rdy);
    int last;
    bit ev;
    @(negedge clk);
    valid_in = v;
    ready_in = rdy;
    pack();
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        check_eq($sformatf("dut%0d reset valid_o", d), DW'(vld_o[d]), DW'(1'b0));
        check_eq($sformatf("dut%0d reset ready_o", d), DW'(rdy_o[d]), DW'(1'b0));
        check_eq($sformatf("dut%0d reset D_o", d), d_o[d], '0);
      end else begin
        last = ps_of[d] - 1;
        ev   = mv[d][last];
        check_eq($sformatf("dut%0d valid_o", d), DW'(vld_o[d]), DW'(ev));
        check_eq($sformatf("dut%0d ready_o", d), DW'(rdy_o[d]), DW'(!ev || rdy));
        if (ev) check_eq($sformatf("dut%0d D_o", d), d_o[d], md[d][last]);
        if (!ev || rdy) begin
          for (int s = last; s > 0; s--) begin
            mv[d][s] = mv[d][s-1];
            md[d][s] = md[d][s-1];
          end
          mv[d][0] = v;
          md[d][0] = ref_d();
        end
      end
    end
    if (rst) clear_model();
  endtask

  task automatic chk_d(input string tag, input int d, input logic [W-1:0] e);
    check_eq(tag, d_o[d], {MN{e}});
  endtask

  task automatic chk_v(input string tag, input int d, input bit e);
    check_eq(tag, DW'(vld_o[d]), DW'(e));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    ps_of[0]  = 2;
    ps_of[1]  = 3;
    rst       = 1'b1;
    valid_in  = 1'b0;
    ready_in  = 1'b1;
    set_uniform(0, 0, 0);
    pack();
    clear_model();

    // Reset held for 2 cycles, then idle.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1);
    chk_d("post-reset D_o", 0, 32'd0);
    check_eq("post-reset ready_o", DW'(rdy_o[0]), DW'(1'b1));
    idle(2);

    // Basic MAC: 1*2 + 1*2 + 3 = 7, two-cycle latency on dut0.
    set_uniform(1, 2, 3);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk_v("basic early valid", 0, 1'b0);
    step(1'b0, 1'b1);
    chk_v("basic valid", 0, 1'b1);
    chk_d("basic D", 0, 32'd7);
    step(1'b0, 1'b1);
    chk_v("basic single beat", 0, 1'b0);
    chk_v("basic tree valid", 1, 1'b1);
    chk_d("basic tree D", 1, 32'd7);
    idle(4);

    // Backpressure: output held for 5 cycles, new beats refused by dut0.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    set_uniform(5, 5, 5);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      chk_v("bp hold valid", 0, 1'b1);
      chk_d("bp hold D", 0, 32'd7);
      check_eq("bp ready_o low", DW'(rdy_o[0]), DW'(1'b0));
    end
    step(1'b0, 1'b1);
    chk_v("bp release valid", 0, 1'b1);
    chk_d("bp release D", 0, 32'd7);
    step(1'b0, 1'b1);
    chk_v("bp drained", 0, 1'b0);
    idle(6);

    // Signed extremes.
    set_uniform(-128, -128, -1);
    step(1'b1, 1'b1);
    idle(1);
    step(1'b0, 1'b1);
    chk_d("extreme neg*neg", 0, 32'd32767);
    set_uniform(127, -128, 0);
    step(1'b1, 1'b1);
    idle(1);
    step(1'b0, 1'b1);
    chk_d("extreme pos*neg", 0, 32'hFFFF_8100);
    idle(4);

    // Streaming C = 0..3 with A = B = 1: results 2..5 on consecutive cycles.
    for (int k = 0; k < 8; k++) begin
      set_uniform(1, 1, k);
      step(k < 4, 1'b1);
      if (k >= 2 && k <= 5) begin
        chk_v("stream valid", 0, 1'b1);
        chk_d("stream D", 0, W'(k));
      end
      if (k >= 3 && k <= 6) begin
        chk_v("stream tree valid", 1, 1'b1);
        chk_d("stream tree D", 1, W'(k - 1));
      end
    end
    idle(4);

    // Overflow of the final add: saturate or wrap depending on the build.
    set_uniform(1, 1, 2147483647);
    step(1'b1, 1'b1);
    idle(1);
    step(1'b0, 1'b1);
`ifdef SYN_TLE_SAT_EN
    chk_d("overflow saturate", 0, 32'h7FFF_FFFF);
`else
    chk_d("overflow wrap", 0, 32'h8000_0001);
`endif
    idle(4);

    // Reset mid-flight: two beats in the pipe are discarded.
    set_uniform(3, 3, 10);
    step(1'b1, 1'b1);
    set_uniform(3, 3, 11);
    step(1'b1, 1'b1);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_v("async reset valid", 0, 1'b0);
    chk_v("async reset tree valid", 1, 1'b0);
    chk_d("async reset D", 0, 32'd0);
    clear_model();
    step(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1);
      chk_v("no ghost output", 0, 1'b0);
    end

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      set_random();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
